smg_display_ctrlmod: RTL and testbench
======================================

SMG_DISPLAY_CTRLMOD -- requirements
Module: smg_display_ctrlmod

Interface
REQ-001 Parameter SHOW_CYC, default 150000000, SHALL set the number of CLOCK cycles alarm view is held (3 s at 50 MHz).
REQ-002 Parameter BLINK_HALF, default 12500000, SHALL set the number of CLOCK cycles in each blink half-period (0.25 s at 50 MHz).
REQ-003 CLOCK  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 iTime  input  24  SHALL carry current time as six BCD nibbles {H1,H0,M1,M0,S1,S0}.
REQ-006 iAlarm  input  24  SHALL carry alarm setting, same packing as iTime.
REQ-007 iAlarmReq  input  1  SHALL be a level request to show the alarm view.
REQ-008 iEditEn  input  1  SHALL be a level request for edit view.
REQ-009 iEditField  input  2  SHALL select the blinking pair: 0=S1S0, 1=M1M0, 2=H1H0, 3=none.
REQ-010 iEditData  input  24  SHALL carry the value being edited, same packing.
REQ-011 oData  output  24  SHALL be the registered six-nibble word driving the display driver iData.
REQ-012 oMode  output  2  SHALL report state: 0=TIME, 1=ALARM, 2=EDIT.
REQ-013 oAlarmAck  output  1  SHALL pulse high one cycle when an alarm request is accepted.

Function
REQ-014 FSM states SHALL be TIME, ALARM, EDIT; encoding matches oMode.
REQ-015 Priority SHALL be iEditEn > iAlarmReq > default TIME, evaluated every cycle.
REQ-016 In any state, iEditEn=1 SHALL move to EDIT next cycle; ALARM hold counter cleared.
REQ-017 In EDIT, iEditEn=0 SHALL return to TIME next cycle, regardless of iAlarmReq that cycle.
REQ-018 In TIME, iAlarmReq=1 with iEditEn=0 SHALL move to ALARM, load hold counter to 0, pulse oAlarmAck.
REQ-019 In ALARM, iAlarmReq=1 SHALL restart hold counter to 0 and pulse oAlarmAck (retrigger).
REQ-020 In ALARM, when hold counter reaches SHOW_CYC-1 with no request, state SHALL return to TIME next cycle.
REQ-021 iAlarmReq while in EDIT SHALL be ignored: no ack, no queuing.
REQ-022 oData SHALL be registered, one-cycle latency: TIME->iTime, ALARM->iAlarm, EDIT->iEditData with blinking.
REQ-023 Blink counter SHALL count 0..BLINK_HALF-1 and wrap, toggling blink phase at wrap; active only in EDIT.
REQ-024 On entry to EDIT, blink counter SHALL clear and phase SHALL be VISIBLE.
REQ-025 In EDIT with phase BLANK, selected pair nibbles SHALL be output as 4'hF (blank code, encoder renders all segments off); other nibbles pass through.
REQ-026 iEditField=3 SHALL disable blanking; iEditField change SHALL take effect next cycle without resetting blink phase.
REQ-027 oMode SHALL be registered and change on the same edge as oData's source change.
REQ-028 Counters SHALL be width ceil(log2(max param)) and never exceed their terminal value.

Reset
REQ-029 RESET=1 SHALL asynchronously force state TIME, oData=24'h000000, oMode=0, oAlarmAck=0, all counters 0, phase VISIBLE.
REQ-030 Reset asserted mid-ALARM or mid-EDIT SHALL abandon the view; first cycle after release shows iTime.
REQ-031 iAlarmReq high at reset release SHALL be accepted on the first post-reset edge with ack.

Verification (SHOW_CYC=10, BLINK_HALF=4)
REQ-032 iTime=24'h123456, no requests -> oData=24'h123456 one cycle later, oMode=0.
REQ-033 iAlarmReq 1-cycle pulse in TIME, iAlarm=24'h070000 -> oAlarmAck one pulse, oData=24'h070000 for 10 cycles, then iTime, oMode 1->0.
REQ-034 Second iAlarmReq at hold count 7 -> second ack, ALARM view extends 10 cycles from retrigger.
REQ-035 iEditEn=1, iEditField=1, iEditData=24'h125930 -> 4 cycles 24'h125930, 4 cycles 24'h12FF30, repeating; iAlarmReq during EDIT gives no ack.
REQ-036 iEditEn and iAlarmReq rise same cycle -> EDIT, no ack; RESET pulse mid-EDIT -> oData=0, oMode=0 immediately, then iTime.

Source files
------------

// File: rtl/smg_display_ctrlmod_if.sv
// Bundle of the display controller's data and request signals.
// The slave modport is the controller's view; the master modport is the
// view of whatever drives the requests and consumes the display word.
interface smg_display_ctrlmod_if;
    logic [23:0] iTime;
    logic [23:0] iAlarm;
    logic        iAlarmReq;
    logic        iEditEn;
    logic [1:0]  iEditField;
    logic [23:0] iEditData;
    logic [23:0] oData;
    logic [1:0]  oMode;
    logic        oAlarmAck;

    modport slave (
        input  iTime, iAlarm, iAlarmReq, iEditEn, iEditField, iEditData,
        output oData, oMode, oAlarmAck
    );

    modport master (
        output iTime, iAlarm, iAlarmReq, iEditEn, iEditField, iEditData,
        input  oData, oMode, oAlarmAck
    );
endinterface

// File: rtl/smg_display_ctrlmod.sv
// Seven-segment display view controller: selects between current time,
// alarm setting (held for SHOW_CYC cycles) and an edit view in which the
// selected digit pair blinks. All outputs are registered.
module smg_display_ctrlmod #(
    parameter int SHOW_CYC   = 150000000,
    parameter int BLINK_HALF = 12500000
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    smg_display_ctrlmod_if.slave     bus
);

    localparam int MAXP = (SHOW_CYC > BLINK_HALF) ? SHOW_CYC : BLINK_HALF;
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] HOLD_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

    // Encoding doubles as the oMode value.
    typedef enum logic [1:0] {
        ST_TIME  = 2'd0,
        ST_ALARM = 2'd1,
        ST_EDIT  = 2'd2
    } state_t;

    // Phase bit: 0 = digits visible, 1 = selected pair blanked.
    localparam logic PH_VISIBLE = 1'b0;

    state_t          r_state;
    logic [CW-1:0]   r_hold;
    logic [CW-1:0]   r_bcnt;
    logic            r_phase;
    logic [23:0]     r_data;
    logic            r_ack;

    state_t          w_nxt;
    logic [CW-1:0]   w_hold_nxt;
    logic [CW-1:0]   w_bcnt_nxt;
    logic            w_phase_nxt;
    logic            w_ack;
    logic [23:0]     w_mask;
    logic [23:0]     w_data;

    // Next-state, counter and ack decode; edit beats alarm beats time.
    always_comb begin
        w_nxt       = ST_TIME;
        w_hold_nxt  = '0;
        w_bcnt_nxt  = '0;
        w_phase_nxt = PH_VISIBLE;
        w_ack       = 1'b0;
        if (bus.iEditEn) begin
            w_nxt = ST_EDIT;
            // Entering edit restarts the blink at visible; staying advances it.
            if (r_state == ST_EDIT) begin
                if (r_bcnt == BLINK_LAST) begin
                    w_bcnt_nxt  = '0;
                    w_phase_nxt = ~r_phase;
                end else begin
                    w_bcnt_nxt  = r_bcnt + 1'b1;
                    w_phase_nxt = r_phase;
                end
            end
        end else if (r_state == ST_EDIT) begin
            // Leaving edit always lands in time view; a pending alarm
            // request this cycle is dropped, not queued.
            w_nxt = ST_TIME;
        end else if (bus.iAlarmReq) begin
            // Accept or retrigger: hold restarts from zero.
            w_nxt = ST_ALARM;
            w_ack = 1'b1;
        end else if (r_state == ST_ALARM) begin
            if (r_hold == HOLD_LAST) begin
                w_nxt = ST_TIME;
            end else begin
                w_nxt      = ST_ALARM;
                w_hold_nxt = r_hold + 1'b1;
            end
        end
    end

    // Nibble mask of the pair chosen for blinking (field 3 selects none).
    always_comb begin
        w_mask = 24'h000000;
        case (bus.iEditField)
            2'd0:    w_mask = 24'h0000FF;
            2'd1:    w_mask = 24'h00FF00;
            2'd2:    w_mask = 24'hFF0000;
            default: w_mask = 24'h000000;
        endcase
    end

    // Display word source follows the next state so data and mode move together.
    always_comb begin
        w_data = bus.iTime;
        case (w_nxt)
            ST_ALARM: w_data = bus.iAlarm;
            ST_EDIT:  w_data = (w_phase_nxt != PH_VISIBLE) ? (bus.iEditData | w_mask)
                                                           : bus.iEditData;
            default:  w_data = bus.iTime;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_TIME;
            r_hold  <= '0;
            r_bcnt  <= '0;
            r_phase <= PH_VISIBLE;
            r_data  <= 24'h000000;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_hold  <= w_hold_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_phase <= w_phase_nxt;
            r_data  <= w_data;
            r_ack   <= w_ack;
        end
    end

    assign bus.oData     = r_data;
    assign bus.oMode     = r_state;
    assign bus.oAlarmAck = r_ack;

endmodule

// File: tb/tb_smg_display_ctrlmod.sv
// Directed bench for smg_display_ctrlmod with short hold/blink periods.
// Expected outputs are queued as stimulus is applied and popped one per clock.
module tb_smg_display_ctrlmod;

    localparam int SHOW = 10;
    localparam int BH   = 4;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    smg_display_ctrlmod_if bus ();

    smg_display_ctrlmod #(.SHOW_CYC(SHOW), .BLINK_HALF(BH)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [23:0] d;
        logic [1:0]  m;
        logic        a;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic push(input logic [23:0] d, input logic [1:0] m, input logic a, input string tag);
        exp_t e;
        e.d = d; e.m = m; e.a = a; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL queue_empty got 0 entries want 1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks += 3;
            assert (bus.oData === e.d) else begin
                failures++;
                $error("FAIL %s oData got %h want %h", e.tag, bus.oData, e.d);
            end
            assert (bus.oMode === e.m) else begin
                failures++;
                $error("FAIL %s oMode got %0d want %0d", e.tag, bus.oMode, e.m);
            end
            assert (bus.oAlarmAck === e.a) else begin
                failures++;
                $error("FAIL %s oAlarmAck got %0b want %0b", e.tag, bus.oAlarmAck, e.a);
            end
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK);
        #1;
        check_now();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ed;
        bus.iTime      = 24'h123456;
        bus.iAlarm     = 24'h070000;
        bus.iAlarmReq  = 1'b0;
        bus.iEditEn    = 1'b0;
        bus.iEditField = 2'd1;
        bus.iEditData  = 24'h125930;

        // Reset state
        @(posedge CLOCK); #1;
        push(24'h000000, 2'd0, 1'b0, "reset");
        check_now();
        RESET = 1'b0;

        // Time view, one-cycle latency
        push(24'h123456, 2'd0, 1'b0, "time0");
        cyc();
        bus.iTime = 24'h235901;
        push(24'h235901, 2'd0, 1'b0, "time1");
        cyc();

        // Alarm: single request, 10 cycle hold, then back to time
        bus.iAlarmReq = 1'b1;
        push(24'h070000, 2'd1, 1'b1, "alm_acc");
        cyc();
        bus.iAlarmReq = 1'b0;
        for (int i = 1; i < SHOW; i++) begin
            push(24'h070000, 2'd1, 1'b0, "alm_hold");
            cyc();
        end
        push(24'h235901, 2'd0, 1'b0, "alm_end");
        cyc();

        // Alarm retrigger at hold count 7
        bus.iAlarmReq = 1'b1;
        push(24'h070000, 2'd1, 1'b1, "rt_acc");
        cyc();
        bus.iAlarmReq = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            push(24'h070000, 2'd1, 1'b0, "rt_hold1");
            cyc();
        end
        bus.iAlarmReq = 1'b1;
        push(24'h070000, 2'd1, 1'b1, "rt_again");
        cyc();
        bus.iAlarmReq = 1'b0;
        for (int i = 1; i < SHOW; i++) begin
            push(24'h070000, 2'd1, 1'b0, "rt_hold2");
            cyc();
        end
        push(24'h235901, 2'd0, 1'b0, "rt_end");
        cyc();

        // Edit view: blink minutes, then no-blank field, then hours
        bus.iEditEn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic blank;
            bus.iEditField = (i < 16) ? 2'd1 : (i < 24) ? 2'd3 : 2'd2;
            bus.iAlarmReq  = (i == 5 || i == 6);
            blank = ((i / BH) % 2) == 1;
            if (!blank || i >= 16 && i < 24) ed = 24'h125930;
            else if (i < 16)                 ed = 24'h12FF30;
            else                             ed = 24'hFF5930;
            push(ed, 2'd2, 1'b0, "edit");
            cyc();
        end

        // Leaving edit with alarm request held: time view, no ack
        bus.iEditEn   = 1'b0;
        bus.iAlarmReq = 1'b1;
        push(24'h235901, 2'd0, 1'b0, "edit_exit");
        cyc();
        bus.iAlarmReq = 1'b0;
        push(24'h235901, 2'd0, 1'b0, "idle");
        cyc();

        // Edit and alarm rising together: edit wins, no ack
        bus.iEditField = 2'd1;
        bus.iEditEn    = 1'b1;
        bus.iAlarmReq  = 1'b1;
        push(24'h125930, 2'd2, 1'b0, "edit_vs_alm");
        cyc();
        bus.iAlarmReq = 1'b0;
        push(24'h125930, 2'd2, 1'b0, "edit_hold");
        cyc();

        // Reset mid-edit takes effect immediately
        RESET = 1'b1;
        #1;
        push(24'h000000, 2'd0, 1'b0, "rst_edit");
        check_now();
        bus.iEditEn = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b0;
        push(24'h235901, 2'd0, 1'b0, "post_rst");
        cyc();

        // Alarm request held through reset release is accepted on first edge
        @(negedge CLOCK);
        RESET = 1'b1;
        bus.iAlarmReq = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        push(24'h070000, 2'd1, 1'b1, "rst_alm");
        cyc();
        bus.iAlarmReq = 1'b0;
        push(24'h070000, 2'd1, 1'b0, "rst_alm_hold");
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
